// File: rtl/clk_mux_freq_monitor.sv
// clk_mux_freq_monitor: counts rising edges of the muxed clock per gate window,
// classifies the active source and flags a stalled clock.
module clk_mux_freq_monitor #(
    parameter int GATE_CYCLES  = 1000,
    parameter int CNT_W        = 16,
    parameter int EXP1         = 250,
    parameter int EXP2         = 375,
    parameter int TOL          = 4,
    parameter int STALL_CYCLES = 64
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             mon_clk,
    input  logic             enable,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic [1:0]       src_detect,
    output logic             src_changed,
    output logic             stall
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic             sync1_q, sync2_q, dly_q;
    logic [GW-1:0]    gate_q;
    logic [CNT_W-1:0] edge_q, edge_d, count_q;
    logic [SW-1:0]    idle_q, idle_d;
    logic [1:0]       src_q, cls;
    logic             valid_q, chg_q, stall_q, edge_det;

    function automatic logic [1:0] classify(input logic [CNT_W-1:0] c);
        int v;
        v = int'(c);
        return (v == 0) ? 2'b00 :
               (v >= EXP1 - TOL && v <= EXP1 + TOL) ? 2'b01 :
               (v >= EXP2 - TOL && v <= EXP2 + TOL) ? 2'b10 : 2'b11;
    endfunction

    // edge_d already includes this cycle's edge, so it is the final count on the last gate cycle
    always_comb begin
        edge_det = sync2_q & ~dly_q;
        edge_d   = (edge_det && edge_q != '1) ? edge_q + 1'b1 : edge_q;
        idle_d   = edge_det ? '0 : (idle_q == STALL_MAX) ? idle_q : idle_q + 1'b1;
        cls      = classify(edge_d);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            gate_q  <= '0;
            edge_q  <= '0;
            idle_q  <= '0;
            count_q <= '0;
            src_q   <= 2'b00;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            sync1_q <= mon_clk;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            if (state_q == IDLE || !enable) begin
                // entering RUN from IDLE, or aborting a window: counters restart clean
                state_q <= enable ? RUN : IDLE;
                gate_q  <= '0;
                edge_q  <= '0;
                idle_q  <= '0;
                stall_q <= 1'b0;
            end else begin
                idle_q  <= idle_d;
                stall_q <= idle_d == STALL_MAX;
                if (gate_q == GATE_LAST) begin
                    gate_q  <= '0;
                    edge_q  <= '0;
                    count_q <= edge_d;
                    valid_q <= 1'b1;
                    src_q   <= cls;
                    chg_q   <= cls != src_q;
                end else begin
                    gate_q <= gate_q + 1'b1;
                    edge_q <= edge_d;
                end
            end
        end
    end

    assign count_out   = count_q;
    assign count_valid = valid_q;
    assign src_detect  = src_q;
    assign src_changed = chg_q;
    assign stall       = stall_q;
endmodule

// File: tb/tb_clk_mux_freq_monitor.sv
// tb_clk_mux_freq_monitor: directed windows at 50/75/60 MHz, stall, disable and reset,
// with a queue of expected window reports checked by an independent monitor.
module tb_clk_mux_freq_monitor;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        mon_clk;
    logic        enable = 1'b0;
    logic [15:0] count_out;
    logic        count_valid;
    logic [1:0]  src_detect;
    logic        src_changed;
    logic        stall;

    typedef struct { int cyc; int lo; int hi; int src; int chg; } exp_t;
    exp_t   q[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     e0, r0;
    longint mon_num = 10000, mon_den = 1;
    longint now, k;

    clk_mux_freq_monitor dut (
        .aclk(aclk), .aresetn(aresetn), .mon_clk(mon_clk), .enable(enable),
        .count_out(count_out), .count_valid(count_valid), .src_detect(src_detect),
        .src_changed(src_changed), .stall(stall)
    );

    always #2500 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // mon_clk toggles at 1000 + k*num/den ps; a fixed origin keeps every frequency clear of aclk edges
    initial begin
        mon_clk = 1'b0;
        #1000;
        forever begin
            if (mon_num == 0) begin
                mon_clk = 1'b0;
                #100;
            end else begin
                now = $time;
                k = ((now - 1000) * mon_den) / mon_num;
                while (1000 + (k * mon_num) / mon_den <= now) k++;
                #(1000 + (k * mon_num) / mon_den - now);
                mon_clk = (k % 2 == 0);
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d..%0d at cycle %0d", nm, act, lo, hi, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge aclk);
    endtask

    task automatic check_zero();
        check("rst_count_out", count_out, 0, 0);
        check("rst_count_valid", count_valid, 0, 0);
        check("rst_src_detect", src_detect, 0, 0);
        check("rst_src_changed", src_changed, 0, 0);
        check("rst_stall", stall, 0, 0);
    endtask

    always @(negedge aclk) begin : mon_b
        exp_t ev;
        if (count_valid) begin
            if (q.size() == 0) check("unexpected_valid", 1, 0, 0);
            else begin
                ev = q.pop_front();
                check("valid_cycle", cyc, ev.cyc, ev.cyc);
                check("count_out", count_out, ev.lo, ev.hi);
                check("src_detect", src_detect, ev.src, ev.src);
                check("src_changed", src_changed, ev.chg, ev.chg);
            end
        end else if (src_changed) check("changed_without_valid", 1, 0, 0);
    end

    initial begin
        wait_cyc(4);
        check_zero();
        aresetn = 1'b1;
        wait_cyc(20);
        check("idle_valid", count_valid, 0, 0);
        check("idle_stall", stall, 0, 0);
        e0 = 20;
        enable = 1'b1;
        q.push_back('{e0 + 1001, 250, 250, 1, 1});
        q.push_back('{e0 + 2001, 250, 250, 1, 0});
        wait_cyc(e0 + 1500);
        check("run_stall_50", stall, 0, 0);
        wait_cyc(e0 + 2501);
        mon_num = 20000; mon_den = 3;
        q.push_back('{e0 + 3001, 300, 325, 3, 1});
        q.push_back('{e0 + 4001, 375, 375, 2, 1});
        q.push_back('{e0 + 5001, 375, 375, 2, 0});
        wait_cyc(e0 + 5501);
        mon_num = 25000; mon_den = 3;
        q.push_back('{e0 + 6001, 325, 350, 3, 1});
        q.push_back('{e0 + 7001, 300, 300, 3, 0});
        q.push_back('{e0 + 8001, 300, 300, 3, 0});
        wait_cyc(e0 + 7500);
        check("run_stall_60", stall, 0, 0);
        wait_cyc(e0 + 8101);
        mon_num = 0;
        q.push_back('{e0 + 9001, 26, 34, 3, 0});
        q.push_back('{e0 + 10001, 0, 0, 0, 1});
        wait_cyc(e0 + 8111);
        check("stall_early", stall, 0, 0);
        wait_cyc(e0 + 8191);
        check("stall_set", stall, 1, 1);
        wait_cyc(e0 + 10201);
        check("stall_held", stall, 1, 1);
        mon_num = 10000; mon_den = 1;
        q.push_back('{e0 + 11001, 196, 203, 3, 1});
        q.push_back('{e0 + 12001, 250, 250, 1, 1});
        @(posedge mon_clk);
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        check("stall_before_clear", stall, 1, 1);
        @(negedge aclk);
        check("stall_cleared", stall, 0, 0);
        wait_cyc(e0 + 12501);
        enable = 1'b0;
        wait_cyc(e0 + 12503);
        check("dis_count_out", count_out, 250, 250);
        check("dis_src_detect", src_detect, 1, 1);
        check("dis_stall", stall, 0, 0);
        wait_cyc(e0 + 13201);
        check("dis_count_kept", count_out, 250, 250);
        check("dis_src_kept", src_detect, 1, 1);
        r0 = e0 + 13201;
        enable = 1'b1;
        q.push_back('{r0 + 1001, 250, 250, 1, 0});
        wait_cyc(r0 + 1301);
        aresetn = 1'b0;
        wait_cyc(r0 + 1302);
        check_zero();
        aresetn = 1'b1;
        q.push_back('{r0 + 2303, 249, 251, 1, 1});
        wait_cyc(r0 + 2330);
        check("pending_windows", q.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
